clk_freq_meter: RTL and testbench
=================================

Name: clk_freq_meter

Overview:
- Measures an incoming slow clock or square wave (for example the output of the team's clock dividers) against the 100 MHz system clock.
- Reports the period and high time in system-clock cycles, with a one-cycle valid strobe per completed period and a timeout flag for a stalled input.
- Used as the consumer/checker end of the divided-clock path, for on-board self-test and for the display of measured frequency.

Parameters:
- CNT_WIDTH, 32, width of the cycle counter and both result outputs.
- TIMEOUT, 1000000, number of clk cycles without a qualifying edge before the timeout flag sets (must be < 2^CNT_WIDTH).
- SYNC_STAGES, 2, depth of the input synchronizer flop chain (minimum 2).

Ports:
- clk  input  1  100 MHz system clock, all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sig_in  input  1  signal under measurement, asynchronous to clk.
- period_count  output  CNT_WIDTH  clk cycles between the last two rising edges of sig_in.
- high_count  output  CNT_WIDTH  clk cycles sig_in was high within that period.
- meas_valid  output  1  one-cycle pulse when period_count/high_count update.
- timeout  output  1  level; set on timeout, cleared on the next meas_valid.

Behaviour:
- Reset (async, active-high): all synchronizer flops, the edge-history flop and counter c go to 0; state goes to S_ARM; period_count=0, high_count=0, meas_valid=0, timeout=0.
- Synchronizer: sig_in passes through SYNC_STAGES flops to give s.
- Edge detect: p is s delayed by one clk. rise = s & ~p; fall = ~s & p; both combinational.
- Counter c: increments by 1 every cycle unless loaded as stated below. Counter wrap is impossible because the timeout triggers first.
- Latency: a sig_in transition sampled on edge E0 produces rise/fall during the cycle after edge E(SYNC_STAGES-1). Registered effects appear after the next edge, i.e. SYNC_STAGES+1 clk edges after E0.
- State S_ARM:
  - c counts up; waits for s==0, then goes to S_WAIT.
  - Prevents a high level at reset release from being taken as a rising edge.
- State S_WAIT: on rise, c<=1 and go to S_HIGH.
- State S_HIGH: on fall, latch hc<=c (internal register) and go to S_LOW.
- State S_LOW: on rise:
  - period_count<=c and high_count<=hc.
  - meas_valid<=1 for exactly one cycle; timeout<=0.
  - c<=1 and go to S_HIGH.
- Counting rule: if rise is detected in cycle t0, c==k during cycle t0+k. The next rise in cycle t1 therefore latches t1-t0; a fall in cycle tf latches tf-t0.
- Timeout:
  - In any state, if c==TIMEOUT and no transition-causing edge occurs in that cycle: timeout<=1, c<=0, go to S_ARM.
  - period_count and high_count hold their last values.
  - The edge takes priority: a rise in S_LOW while c==TIMEOUT is a valid measurement.
- First valid result after reset or timeout requires two rising edges; no meas_valid is generated for the partial first period.
- meas_valid is never asserted in two consecutive cycles; the minimum spacing equals the measured period.
- Minimum measurable input: high 1 cycle, low 1 cycle (period 2) when sig_in is clk-synchronous.
- Reset mid-measurement: immediate async clear to the reset values; no strobe is generated.

Test Plan:
1. sig_in high 20400 / low 20400 clk cycles (100 MHz / 40800 divided clock), repeating -> after the second rise, meas_valid pulses with period_count=40800 and high_count=20400; it then repeats every 40800 cycles.
2. Asymmetric: high 3, low 7, repeating -> period_count=10, high_count=3. Also high 1, low 1 -> period_count=2, high_count=1; each period yields exactly one 1-cycle meas_valid.
3. sig_in held 1 through reset release, dropping after 50 cycles, then high 5 / low 5 -> no meas_valid before the second genuine rise; first result is period_count=10, high_count=5.
4. TIMEOUT=100: after valid measurements, hold sig_in at 0 -> timeout goes high 101 cycles after the last rise-detect cycle; period_count/high_count are unchanged; resuming the toggling clears timeout at the next meas_valid.
5. TIMEOUT=100, period exactly 100 cycles -> meas_valid with period_count=100 and timeout stays 0. Period 101 -> timeout=1 and no meas_valid for that period.
6. Assert rst asynchronously in the middle of S_LOW -> all outputs are 0 before the next clk edge; after release, behaviour matches scenario 1 from a fresh start.

Source files
------------

// File: rtl/clk_freq_meter_if.sv
// Measurement result bus of clk_freq_meter.
// master: the meter, drives the results. slave: the consumer, reads them.
//   period_count  clk cycles between the last two rising edges of the input
//   high_count    clk cycles the input was high within that period
//   meas_valid    one-cycle strobe when period_count/high_count update
//   timeout       level, set on a stalled input, cleared by the next meas_valid
interface clk_freq_meter_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [CNT_WIDTH-1:0] period_count;
    logic [CNT_WIDTH-1:0] high_count;
    logic                 meas_valid;
    logic                 timeout;

    modport master (
        output period_count,
        output high_count,
        output meas_valid,
        output timeout
    );

    modport slave (
        input period_count,
        input high_count,
        input meas_valid,
        input timeout
    );
endinterface

// File: rtl/clk_freq_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Ports:
//   clk     system clock, all logic on its rising edge
//   rst     asynchronous active-high reset
//   sig_in  signal under measurement, asynchronous to clk
//   res     result bus (period_count, high_count, meas_valid, timeout)
module clk_freq_meter #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    clk_freq_meter_if.master res
);
    localparam logic [CNT_WIDTH-1:0] TMO_LIMIT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] SYNC_FILL = CNT_WIDTH'(SYNC_STAGES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_WAIT = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   p_q;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    state_t                 state_nxt;
    state_t                 adv_state;
    logic                   adv;
    logic                   primed;
    logic                   tmo_hit;

    logic [CNT_WIDTH-1:0]   c_q,    c_nxt;
    logic [CNT_WIDTH-1:0]   hc_q,   hc_nxt;
    logic [CNT_WIDTH-1:0]   pc_q,   pc_nxt;
    logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_nxt;
    logic                   mv_q,   mv_nxt;
    logic                   to_q,   to_nxt;

    // Input synchronizer and edge-history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            p_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            p_q    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p_q;
    assign fall = ~s & p_q;

    // The cleared synchronizer shows a false low until it has refilled after reset,
    // so arming waits until c has covered the chain depth.
    assign primed  = (c_q >= SYNC_FILL);
    assign tmo_hit = (c_q >= TMO_LIMIT);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_ARM;
            c_q    <= '0;
            hc_q   <= '0;
            pc_q   <= '0;
            hcnt_q <= '0;
            mv_q   <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            c_q    <= c_nxt;
            hc_q   <= hc_nxt;
            pc_q   <= pc_nxt;
            hcnt_q <= hcnt_nxt;
            mv_q   <= mv_nxt;
            to_q   <= to_nxt;
        end
    end

    // Next state: a qualifying edge beats the timeout.
    always_comb begin
        adv       = 1'b0;
        adv_state = state;
        state_nxt = state;
        case (state)
            S_ARM:   begin adv = ~s & primed; adv_state = S_WAIT; end
            S_WAIT:  begin adv = rise;        adv_state = S_HIGH; end
            S_HIGH:  begin adv = fall;        adv_state = S_LOW;  end
            S_LOW:   begin adv = rise;        adv_state = S_HIGH; end
            default: begin adv = 1'b0;        adv_state = S_ARM;  end
        endcase
        if (adv) begin
            state_nxt = adv_state;
        end else if (tmo_hit) begin
            state_nxt = S_ARM;
        end
    end

    // Counter, latches and result outputs.
    always_comb begin
        c_nxt    = c_q + CNT_ONE;
        hc_nxt   = hc_q;
        pc_nxt   = pc_q;
        hcnt_nxt = hcnt_q;
        mv_nxt   = 1'b0;
        to_nxt   = to_q;
        if (adv) begin
            case (state)
                S_WAIT: c_nxt = CNT_ONE;
                S_HIGH: hc_nxt = c_q;
                S_LOW: begin
                    pc_nxt   = c_q;
                    hcnt_nxt = hc_q;
                    mv_nxt   = 1'b1;
                    to_nxt   = 1'b0;
                    c_nxt    = CNT_ONE;
                end
                default: ;
            endcase
        end else if (tmo_hit) begin
            to_nxt = 1'b1;
            c_nxt  = '0;
        end
    end

    assign res.period_count = pc_q;
    assign res.high_count   = hcnt_q;
    assign res.meas_valid   = mv_q;
    assign res.timeout      = to_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two instances (long and short timeout) checked every
// cycle against an event/timestamp model, plus hand-computed expectations.
module tb_clk_freq_meter;
    localparam int unsigned CW   = 32;
    localparam int unsigned SS   = 2;
    localparam int unsigned TO_A = 1000000;
    localparam int unsigned TO_B = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic sig_a = 1'b0;
    logic sig_b = 1'b0;

    clk_freq_meter_if #(.CNT_WIDTH(CW)) res_a ();
    clk_freq_meter_if #(.CNT_WIDTH(CW)) res_b ();

    clk_freq_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO_A), .SYNC_STAGES(SS)) dut_a (
        .clk(clk), .rst(rst_a), .sig_in(sig_a), .res(res_a.master));
    clk_freq_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO_B), .SYNC_STAGES(SS)) dut_b (
        .clk(clk), .rst(rst_b), .sig_in(sig_b), .res(res_b.master));

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    bit done_a = 1'b0;
    bit done_b = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: timestamps of the last rise/fall on the synchronized view of the input.
    typedef struct {
        bit [SS:0] sh;
        longint    cyc;
        longint    t_base;
        longint    t_rise;
        longint    hc_lat;
        longint    pc;
        longint    hcnt;
        bit        seen_low;
        bit        has_rise;
        bit        fall_seen;
        bit        mv;
        bit        to;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.sh = '0; m.cyc = 0; m.t_base = 0; m.t_rise = 0; m.hc_lat = 0;
        m.pc = 0; m.hcnt = 0; m.seen_low = 0; m.has_rise = 0; m.fall_seen = 0;
        m.mv = 0; m.to = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m_in, input bit din, input longint tmo);
        model_t m;
        bit s_c, p_c, r, f, taken;
        longint e;
        m     = m_in;
        s_c   = m.sh[SS-1];
        p_c   = m.sh[SS];
        r     = s_c & ~p_c;
        f     = ~s_c & p_c;
        e     = m.cyc - m.t_base;
        taken = 0;
        m.mv  = 0;
        if (!m.seen_low) begin
            if (!s_c && e >= SS) begin m.seen_low = 1; taken = 1; end
        end else if (!m.has_rise) begin
            if (r) begin m.has_rise = 1; m.t_rise = m.cyc; m.t_base = m.cyc; m.fall_seen = 0; taken = 1; end
        end else if (!m.fall_seen) begin
            if (f) begin m.hc_lat = m.cyc - m.t_rise; m.fall_seen = 1; taken = 1; end
        end else if (r) begin
            m.pc = m.cyc - m.t_rise; m.hcnt = m.hc_lat; m.mv = 1; m.to = 0;
            m.t_rise = m.cyc; m.t_base = m.cyc; m.fall_seen = 0; taken = 1;
        end
        if (!taken && e >= tmo) begin
            m.to = 1; m.t_base = m.cyc + 1; m.seen_low = 0; m.has_rise = 0; m.fall_seen = 0;
        end
        m.sh  = {m.sh[SS-1:0], din};
        m.cyc = m.cyc + 1;
        return m;
    endfunction

    model_t ma, mb;
    always @(posedge clk or posedge rst_a) if (rst_a) ma <= model_reset(); else ma <= model_step(ma, sig_a, TO_A);
    always @(posedge clk or posedge rst_b) if (rst_b) mb <= model_reset(); else mb <= model_step(mb, sig_b, TO_B);

    longint qa_p[$], qa_h[$], qb_p[$], qb_h[$];
    logic mv_prev_a = 1'b0;
    logic mv_prev_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_a) begin
            chk("a_period_count", res_a.period_count, ma.pc);
            chk("a_high_count",   res_a.high_count,   ma.hcnt);
            chk("a_meas_valid",   res_a.meas_valid,   ma.mv);
            chk("a_timeout",      res_a.timeout,      ma.to);
            if (res_a.meas_valid) begin
                chk("a_mv_spacing", mv_prev_a, 0);
                qa_p.push_back(res_a.period_count);
                qa_h.push_back(res_a.high_count);
            end
            mv_prev_a <= res_a.meas_valid;
        end else begin
            mv_prev_a <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            chk("b_period_count", res_b.period_count, mb.pc);
            chk("b_high_count",   res_b.high_count,   mb.hcnt);
            chk("b_meas_valid",   res_b.meas_valid,   mb.mv);
            chk("b_timeout",      res_b.timeout,      mb.to);
            if (res_b.meas_valid) begin
                chk("b_mv_spacing", mv_prev_b, 0);
                qb_p.push_back(res_b.period_count);
                qb_h.push_back(res_b.high_count);
            end
            mv_prev_b <= res_b.meas_valid;
        end else begin
            mv_prev_b <= 1'b0;
        end
    end

    task automatic drive(input int which, input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            if (which == 0) sig_a = v; else sig_b = v;
        end
    endtask

    task automatic per(input int which, input int h, input int l);
        drive(which, 1'b1, h);
        drive(which, 1'b0, l);
    endtask

    longint exp_ap[5]  = '{10, 10, 10, 10, 40800};
    longint exp_ah[5]  = '{4, 4, 4, 4, 20400};
    longint exp_bp[18] = '{10, 10, 10, 10, 10, 10, 10, 10, 2, 2, 2, 2, 2, 10, 10, 10, 100, 10};
    longint exp_bh[18] = '{5, 5, 5, 5, 3, 3, 3, 3, 1, 1, 1, 1, 1, 5, 5, 5, 50, 5};

    // Instance A: short periods, async reset inside S_LOW, then 40800-cycle period.
    initial begin
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        drive(0, 1'b0, 5);
        repeat (4) per(0, 4, 6);
        drive(0, 1'b1, 4);
        drive(0, 1'b0, 6);
        chk("a_pc_before_rst", res_a.period_count, 10);
        chk("a_pulses_before_rst", qa_p.size(), 4);
        #2 rst_a = 1'b1;
        #1;
        chk("a_rst_period_count", res_a.period_count, 0);
        chk("a_rst_high_count",   res_a.high_count,   0);
        chk("a_rst_meas_valid",   res_a.meas_valid,   0);
        chk("a_rst_timeout",      res_a.timeout,      0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 20400);
        drive(0, 1'b0, 20400);
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 10);
        chk("a_pulse_count", qa_p.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < qa_p.size()) begin
                chk($sformatf("a_pulse%0d_period", i), qa_p[i], exp_ap[i]);
                chk($sformatf("a_pulse%0d_high", i),   qa_h[i], exp_ah[i]);
            end
        end
        done_a = 1'b1;
    end

    // Instance B: high at reset release, asymmetric and minimum periods, timeouts.
    initial begin
        longint n14, t_to;
        sig_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        drive(1, 1'b1, 50);
        drive(1, 1'b0, 5);
        repeat (4) per(1, 5, 5);
        chk("b_s3_pulses", qb_p.size(), 3);
        repeat (4) per(1, 3, 7);
        repeat (5) per(1, 1, 1);
        @(negedge clk);
        sig_b = 1'b1;
        n14 = ecnt;
        @(negedge clk);
        sig_b = 1'b0;
        t_to = -1;
        repeat (150) begin
            @(negedge clk);
            if (res_b.timeout && t_to < 0) t_to = ecnt;
            sig_b = 1'b0;
        end
        chk("b_timeout_latency", t_to - n14, 103);
        chk("b_timeout_level", res_b.timeout, 1);
        chk("b_hold_period", res_b.period_count, 2);
        chk("b_hold_high", res_b.high_count, 1);
        repeat (3) per(1, 5, 5);
        chk("b_timeout_cleared", res_b.timeout, 0);
        per(1, 50, 50);
        drive(1, 1'b1, 10);
        chk("b_p100_period", res_b.period_count, 100);
        chk("b_p100_high", res_b.high_count, 50);
        chk("b_p100_timeout", res_b.timeout, 0);
        drive(1, 1'b1, 40);
        drive(1, 1'b0, 51);
        drive(1, 1'b1, 5);
        chk("b_p101_timeout", res_b.timeout, 1);
        chk("b_p101_no_pulse", qb_p.size(), 17);
        drive(1, 1'b0, 5);
        repeat (2) per(1, 5, 5);
        chk("b_end_timeout", res_b.timeout, 0);
        chk("b_pulse_count", qb_p.size(), 18);
        for (int i = 0; i < 18; i++) begin
            if (i < qb_p.size()) begin
                chk($sformatf("b_pulse%0d_period", i), qb_p[i], exp_bp[i]);
                chk($sformatf("b_pulse%0d_high", i),   qb_h[i], exp_bh[i]);
            end
        end
        done_b = 1'b1;
    end

    initial begin
        for (int i = 0; i < 60000; i++) begin
            if (done_a && done_b) break;
            @(posedge clk);
        end
        chk("stimulus_done", {63'b0, done_a & done_b}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
